state_sequencer: RTL and testbench

Parametrised state-sequence generator: advances a WIDTH-bit state register from a loaded seed using one of four selectable update modes (accumulate, LFSR, rotate, hold). It runs freely while `play` is high or single-steps on `step` pulses. It sits between the board input logic (seed/mode switches, play/step buttons) and the display/game logic that consumes `next_state`. It also reports an advance strobe, an accumulator wrap flag and an advance counter.

---
 rtl/state_sequencer.sv | 112 +++++++++++
 tb/tb_state_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// Seed-loaded WIDTH-bit state generator: accumulate, LFSR, rotate-left or hold,
// free-running in RUN or single-stepped in PAUSED. Option: STATE_SEQ_ZERO_GUARD_EN.
module state_sequencer #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] TAPS    = 6'b110000,
    parameter int               COUNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    input  logic [1:0]         mode,
    input  logic               play,
    input  logic               step,
    output logic [WIDTH-1:0]   next_state,
    output logic               adv,
    output logic               wrap,
    output logic               running,
    output logic [COUNT_W-1:0] adv_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PAUSED = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam logic [1:0] MODE_ACC  = 2'b00;
    localparam logic [1:0] MODE_LFSR = 2'b01;
    localparam logic [1:0] MODE_ROT  = 2'b10;

    logic [1:0]         fsm_q,   fsm_d;
    logic [WIDTH-1:0]   state_q, state_d;
    logic               adv_q,   adv_d;
    logic               wrap_q,  wrap_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               advance;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   lfsr_next;
    logic [WIDTH-1:0]   update;

    always_comb begin
        advance = !load && (((fsm_q == RUN) && play) || ((fsm_q == PAUSED) && step));
        sum     = {1'b0, state_q} + {1'b0, seed};

        lfsr_next = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
`ifdef STATE_SEQ_ZERO_GUARD_EN
        // An all-zero LFSR would never leave zero, so substitute 1.
        if (lfsr_next == '0) begin
            lfsr_next = {{(WIDTH-1){1'b0}}, 1'b1};
        end
`endif

        case (mode)
            MODE_ACC:  update = sum[WIDTH-1:0];
            MODE_LFSR: update = lfsr_next;
            MODE_ROT:  update = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
            default:   update = state_q;
        endcase
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        adv_d   = 1'b0;
        wrap_d  = 1'b0;
        count_d = count_q;

        if (load) begin
            state_d = seed;
            count_d = '0;
            if (fsm_q == IDLE) begin
                fsm_d = PAUSED;
            end
        end else begin
            if (advance) begin
                state_d = update;
                adv_d   = 1'b1;
                wrap_d  = (mode == MODE_ACC) && sum[WIDTH];
                count_d = count_q + 1'b1;
            end
            // A dropped play leaves RUN without advancing on that edge.
            case (fsm_q)
                PAUSED:  if (play) fsm_d = RUN;
                RUN:     if (!play) fsm_d = PAUSED;
                default: fsm_d = fsm_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            adv_q   <= 1'b0;
            wrap_q  <= 1'b0;
            count_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            adv_q   <= adv_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
        end
    end

    assign next_state = state_q;
    assign adv        = adv_q;
    assign wrap       = wrap_q;
    assign running    = (fsm_q == RUN);
    assign adv_count  = count_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: a behavioural model pushes the expected
// outputs for each driven cycle, which are popped and compared after the edge.
module tb_state_sequencer;

    localparam int W  = 6;
    localparam int CW = 16;

    logic          clk_in;
    logic          rst;
    logic          load;
    logic [W-1:0]  seed;
    logic [1:0]    mode;
    logic          play;
    logic          step;
    logic [W-1:0]  next_state;
    logic          adv;
    logic          wrap;
    logic          running;
    logic [CW-1:0] adv_count;

    typedef struct packed {
        logic [W-1:0]  st;
        logic          adv;
        logic          wrap;
        logic          run;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int total;
    int bad;

    // Behavioural model state, written from the stimulus process only
    int            m_fsm;
    logic [W-1:0]  m_state;
    logic [CW-1:0] m_count;

    state_sequencer #(.WIDTH(W), .TAPS(6'b110000), .COUNT_W(CW)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .load       (load),
        .seed       (seed),
        .mode       (mode),
        .play       (play),
        .step       (step),
        .next_state (next_state),
        .adv        (adv),
        .wrap       (wrap),
        .running    (running),
        .adv_count  (adv_count)
    );

    // Free-running 10-unit clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of one clock edge; returns the expected post-edge outputs
    function automatic exp_t modelEdge(input logic r, input logic ld, input logic [W-1:0] sd,
                                       input logic [1:0] md, input logic pl, input logic stp);
        exp_t e;
        logic [W:0] s;
        logic go;
        e = '0;
        if (r) begin
            m_fsm = 0; m_state = '0; m_count = '0;
        end else if (ld) begin
            m_state = sd;
            m_count = '0;
            if (m_fsm == 0) m_fsm = 1;
        end else begin
            go = (m_fsm == 2 && pl) || (m_fsm == 1 && stp);
            if (go) begin
                e.adv = 1'b1;
                m_count = m_count + 1'b1;
                case (md)
                    2'b00: begin
                        s = {1'b0, m_state} + {1'b0, sd};
                        m_state = s[W-1:0];
                        e.wrap = s[W];
                    end
                    2'b01: begin
                        m_state = {m_state[W-2:0], m_state[5] ^ m_state[4]};
`ifdef STATE_SEQ_ZERO_GUARD_EN
                        if (m_state == 0) m_state = 6'd1;
`endif
                    end
                    2'b10: m_state = {m_state[W-2:0], m_state[W-1]};
                    default: m_state = m_state;
                endcase
            end
            if (m_fsm == 1 && pl) m_fsm = 2;
            else if (m_fsm == 2 && !pl) m_fsm = 1;
        end
        e.st  = m_state;
        e.run = (m_fsm == 2);
        e.cnt = m_count;
        return e;
    endfunction

    // Drive one cycle on the falling edge, push expectation, compare after the edge
    task automatic applyStimulus(input logic r, input logic ld, input logic [W-1:0] sd,
                                 input logic [1:0] md, input logic pl, input logic stp);
        exp_t e;
        @(negedge clk_in);
        rst = r; load = ld; seed = sd; mode = md; play = pl; step = stp;
        sb.push_back(modelEdge(r, ld, sd, md, pl, stp));
        @(posedge clk_in);
        #1;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkOutput("state",   32'(next_state), 32'(e.st));
            checkOutput("adv",     32'(adv),        32'(e.adv));
            checkOutput("wrap",    32'(wrap),       32'(e.wrap));
            checkOutput("running", 32'(running),    32'(e.run));
            checkOutput("count",   32'(adv_count),  32'(e.cnt));
        end
    endtask

    logic [W-1:0] lfsr_exp [6];
    int seen_one;

    initial begin
        total = 0; bad = 0;
        m_fsm = 0; m_state = '0; m_count = '0;
        rst = 1'b1; load = 1'b0; seed = '0; mode = 2'b00; play = 1'b0; step = 1'b0;
        lfsr_exp[0] = 6'b000010; lfsr_exp[1] = 6'b000100; lfsr_exp[2] = 6'b001000;
        lfsr_exp[3] = 6'b010000; lfsr_exp[4] = 6'b100001; lfsr_exp[5] = 6'b000011;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_state", 32'(next_state), 32'd0);
        checkOutput("reset_run",   32'(running),    32'd0);

        // IDLE ignores play and step
        applyStimulus(0, 0, 6'd5, 0, 1, 1);
        applyStimulus(0, 0, 6'd5, 0, 1, 0);

        // Accumulate by 5 until the carry
        applyStimulus(0, 1, 6'd5, 0, 1, 0);
        checkOutput("acc_load", 32'(next_state), 32'd5);
        applyStimulus(0, 0, 6'd5, 0, 1, 0);
        checkOutput("acc_enter_run", 32'(running), 32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 6'd5, 0, 1, 0);
        checkOutput("acc_wrap_state", 32'(next_state), 32'd1);
        checkOutput("acc_wrap_flag",  32'(wrap),       32'd1);
        checkOutput("acc_wrap_count", 32'(adv_count),  32'd12);
        applyStimulus(0, 0, 6'd5, 0, 1, 0);
        checkOutput("acc_wrap_clear", 32'(wrap), 32'd0);

        // LFSR: load in RUN stays RUN, then pause and single-step
        applyStimulus(0, 1, 6'd1, 2'b01, 0, 0);
        applyStimulus(0, 0, 6'd1, 2'b01, 0, 0);
        checkOutput("pause_from_run", 32'(running), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 6'd1, 2'b01, 0, 1);
            checkOutput("lfsr_step", 32'(next_state), 32'(lfsr_exp[i]));
        end

        // Full LFSR period from 000001
        applyStimulus(0, 1, 6'd1, 2'b01, 0, 0);
        applyStimulus(0, 0, 6'd1, 2'b01, 1, 0);
        seen_one = 0;
        for (int i = 0; i < 63; i++) begin
            applyStimulus(0, 0, 6'd1, 2'b01, 1, 0);
            if (i < 62 && next_state == 6'd1) seen_one = seen_one + 1;
        end
        checkOutput("lfsr_early_repeat", 32'(seen_one),  32'd0);
        checkOutput("lfsr_period",       32'(next_state), 32'd1);

        // Rotate: load, one step, then step held six cycles
        applyStimulus(0, 1, 6'b000101, 2'b10, 0, 0);
        applyStimulus(0, 0, 6'b000101, 2'b10, 0, 0);
        applyStimulus(0, 1, 6'b000101, 2'b10, 0, 0);
        applyStimulus(0, 0, 6'b000101, 2'b10, 0, 1);
        checkOutput("rot_one", 32'(next_state), 32'b001010);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 6'b000101, 2'b10, 0, 1);
        checkOutput("rot_held",  32'(next_state), 32'b001010);
        checkOutput("rot_count", 32'(adv_count),  32'd7);

        // Load and step together: load wins
        applyStimulus(0, 1, 6'd9, 2'b10, 0, 1);
        checkOutput("load_step_state", 32'(next_state), 32'd9);
        checkOutput("load_step_adv",   32'(adv),        32'd0);

        // Hold mode still counts advances
        applyStimulus(0, 0, 6'd9, 2'b11, 0, 1);
        checkOutput("hold_state", 32'(next_state), 32'd9);
        checkOutput("hold_count", 32'(adv_count),  32'd1);

        // Run, drop play mid-sequence, then idle in PAUSED
        applyStimulus(0, 0, 6'd9, 2'b10, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'd9, 2'b10, 1, 0);
        applyStimulus(0, 0, 6'd9, 2'b10, 0, 0);
        checkOutput("drop_adv", 32'(adv), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'd9, 2'b10, 0, 0);
        applyStimulus(0, 0, 6'd9, 2'b00, 0, 1);

        // Reset mid-run clears everything and IDLE ignores play/step
        applyStimulus(0, 0, 6'd3, 2'b00, 1, 0);
        applyStimulus(0, 0, 6'd3, 2'b00, 1, 0);
        applyStimulus(1, 0, 6'd3, 2'b00, 1, 0);
        checkOutput("rst_run_state", 32'(next_state), 32'd0);
        checkOutput("rst_run_count", 32'(adv_count),  32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'd3, 2'b00, 1, 1);
        checkOutput("idle_ignore", 32'(adv_count), 32'd0);

        // Zero seed in LFSR mode
        applyStimulus(0, 1, 6'd0, 2'b01, 0, 0);
        applyStimulus(0, 0, 6'd0, 2'b01, 0, 1);
`ifdef STATE_SEQ_ZERO_GUARD_EN
        checkOutput("zero_guard", 32'(next_state), 32'd1);
`else
        checkOutput("zero_guard", 32'(next_state), 32'd0);
`endif
        checkOutput("zero_adv", 32'(adv), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
